// File: rtl/lrn_window_buffer_if.sv
// Bundle of signals between lrn_window_buffer and the mapper, feature memory and datapath.
// master drives strobes, read data and ready; slave is the window buffer.
interface lrn_window_buffer_if #(
   parameter int DATA_WIDTH = 16,
   parameter int M_WIDTH    = 10
);
   logic [M_WIDTH-1:0]    dim3;
   logic                  r_enable;
   logic [DATA_WIDTH-1:0] r_data;
   logic                  full_flag;
   logic [DATA_WIDTH-1:0] s_data;
   logic                  s_valid;
   logic                  s_ready;
   logic                  w_enable;
   logic                  normalized_window;
   logic                  overflow_err;
   logic                  config_err;

   modport master (
      output dim3, r_enable, r_data, s_ready, w_enable,
      input  full_flag, s_data, s_valid, normalized_window, overflow_err, config_err
   );

   modport slave (
      input  dim3, r_enable, r_data, s_ready, w_enable,
      output full_flag, s_data, s_valid, normalized_window, overflow_err, config_err
   );
endinterface

// File: rtl/lrn_window_buffer.sv
// Captures one LRN channel window from feature memory, streams it out and tracks write-backs.
// Optional sticky error flags are built only when LRN_WBUF_ERR_EN is defined.
module lrn_window_buffer #(
   parameter int DATA_WIDTH = 16,
   parameter int M_WIDTH    = 10,
   parameter int DEPTH      = 1024,
   parameter int RD_LATENCY = 2
) (
   input logic                 core_clk,
   input logic                 reset,
   lrn_window_buffer_if.slave  bus
);
   localparam int              AW = $clog2(DEPTH);
   localparam int              CW = M_WIDTH + 1;
   localparam logic [CW-1:0]   ONE = CW'(1);
   localparam logic [31:0]     DEPTH_U = DEPTH;

   typedef enum logic [2:0] {IDLE, FILL, DRAIN, COLLECT, DONE} state_t;

   state_t                 state_reg;
   logic [RD_LATENCY-1:0]  rv_pipe_reg;
   logic [CW-1:0]          win_len_reg;
   logic [CW-1:0]          fill_cnt_reg;
   logic [CW-1:0]          rd_ptr_reg;
   logic [CW-1:0]          hs_cnt_reg;
   logic [CW-1:0]          wb_cnt_reg;
   logic                   full_flag_reg;
   logic                   s_valid_reg;
   logic                   norm_reg;
   logic [DATA_WIDTH-1:0]  s_data_reg;
   logic [DATA_WIDTH-1:0]  mem [DEPTH];

   logic                   r_valid;
   logic                   bad_dim;
   logic                   start;
   logic                   mem_we;
   logic [AW-1:0]          mem_waddr;
   logic                   rd_en;
   logic                   handshake;
   logic                   last_hs;
   logic                   wb_count_en;
   logic [CW-1:0]          wb_cnt_next;
   logic [CW-1:0]          fill_cnt_inc;
   logic [CW-1:0]          hs_cnt_inc;

   // Read-valid pipeline mirrors the memory's fixed read latency.
   for (genvar gi = 0; gi < RD_LATENCY; gi++) begin : g_rv_pipe
      if (gi == 0) begin : g_head
         always_ff @(posedge core_clk) begin
            if (reset) rv_pipe_reg[gi] <= 1'b0;
            else       rv_pipe_reg[gi] <= bus.r_enable;
         end
      end else begin : g_tail
         always_ff @(posedge core_clk) begin
            if (reset) rv_pipe_reg[gi] <= 1'b0;
            else       rv_pipe_reg[gi] <= rv_pipe_reg[gi-1];
         end
      end
   end

   assign r_valid      = rv_pipe_reg[RD_LATENCY-1];
   assign bad_dim      = (bus.dim3 == '0) || (32'(bus.dim3) > DEPTH_U);
   assign start        = r_valid && (state_reg == IDLE || state_reg == DONE) && !bad_dim;
   assign mem_we       = start || (r_valid && state_reg == FILL);
   assign mem_waddr    = start ? '0 : AW'(fill_cnt_reg);
   assign handshake    = s_valid_reg && bus.s_ready;
   assign hs_cnt_inc   = hs_cnt_reg + ONE;
   assign fill_cnt_inc = fill_cnt_reg + ONE;
   assign last_hs      = handshake && (hs_cnt_inc == win_len_reg);
   assign rd_en        = (state_reg == DRAIN) && (rd_ptr_reg < win_len_reg)
                         && (!s_valid_reg || bus.s_ready);
   assign wb_count_en  = bus.w_enable && (state_reg == DRAIN || state_reg == COLLECT)
                         && (wb_cnt_reg < win_len_reg);
   assign wb_cnt_next  = wb_count_en ? wb_cnt_reg + ONE : wb_cnt_reg;

   always_ff @(posedge core_clk) begin
      if (mem_we) mem[mem_waddr] <= bus.r_data;
   end

   // Registered buffer read doubles as the output data register.
   always_ff @(posedge core_clk) begin
      if (reset)      s_data_reg <= '0;
      else if (rd_en) s_data_reg <= mem[AW'(rd_ptr_reg)];
   end

   always_ff @(posedge core_clk) begin
      if (reset) begin
         state_reg     <= IDLE;
         win_len_reg   <= '0;
         fill_cnt_reg  <= '0;
         rd_ptr_reg    <= '0;
         hs_cnt_reg    <= '0;
         wb_cnt_reg    <= '0;
         full_flag_reg <= 1'b0;
         s_valid_reg   <= 1'b0;
         norm_reg      <= 1'b0;
      end else begin
         wb_cnt_reg <= wb_cnt_next;
         if (handshake) hs_cnt_reg <= hs_cnt_inc;
         if (rd_en) begin
            rd_ptr_reg  <= rd_ptr_reg + ONE;
            s_valid_reg <= 1'b1;
         end else if (handshake) begin
            s_valid_reg <= 1'b0;
         end

         case (state_reg)
            IDLE, DONE: begin
               if (start) begin
                  win_len_reg  <= CW'(bus.dim3);
                  fill_cnt_reg <= ONE;
                  rd_ptr_reg   <= '0;
                  hs_cnt_reg   <= '0;
                  wb_cnt_reg   <= '0;
                  norm_reg     <= 1'b0;
                  if (bus.dim3 == M_WIDTH'(1)) begin
                     state_reg     <= DRAIN;
                     full_flag_reg <= 1'b1;
                  end else begin
                     state_reg <= FILL;
                  end
               end
            end
            FILL: begin
               if (r_valid) begin
                  fill_cnt_reg <= fill_cnt_inc;
                  if (fill_cnt_inc == win_len_reg) begin
                     state_reg     <= DRAIN;
                     full_flag_reg <= 1'b1;
                  end
               end
            end
            DRAIN: begin
               if (last_hs) begin
                  if (wb_cnt_next == win_len_reg) begin
                     state_reg     <= DONE;
                     full_flag_reg <= 1'b0;
                     norm_reg      <= 1'b1;
                  end else begin
                     state_reg <= COLLECT;
                  end
               end
            end
            COLLECT: begin
               if (wb_cnt_next == win_len_reg) begin
                  state_reg     <= DONE;
                  full_flag_reg <= 1'b0;
                  norm_reg      <= 1'b1;
               end
            end
            default: begin
               state_reg     <= IDLE;
               full_flag_reg <= 1'b0;
            end
         endcase
      end
   end

`ifdef LRN_WBUF_ERR_EN
   logic overflow_err_reg;
   logic config_err_reg;

   // Sticky: only reset clears them.
   always_ff @(posedge core_clk) begin
      if (reset) begin
         overflow_err_reg <= 1'b0;
         config_err_reg   <= 1'b0;
      end else begin
         if (r_valid && (state_reg == DRAIN || state_reg == COLLECT))
            overflow_err_reg <= 1'b1;
         if (r_valid && (state_reg == IDLE || state_reg == DONE) && bad_dim)
            config_err_reg <= 1'b1;
      end
   end

   assign bus.overflow_err = overflow_err_reg;
   assign bus.config_err   = config_err_reg;
`else
   assign bus.overflow_err = 1'b0;
   assign bus.config_err   = 1'b0;
`endif

   assign bus.full_flag         = full_flag_reg;
   assign bus.s_valid           = s_valid_reg;
   assign bus.s_data            = s_data_reg;
   assign bus.normalized_window = norm_reg;
endmodule

// File: tb/tb_lrn_window_buffer.sv
// Randomized bench for lrn_window_buffer: a latency-accurate memory model feeds windows,
// and expected samples and event timing are derived from the window-level rules.
module tb_lrn_window_buffer;
   localparam int DW    = 16;
   localparam int MW    = 10;
   localparam int DEPTH = 1024;
   localparam int L     = 2;
`ifdef LRN_WBUF_ERR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic core_clk = 1'b0;
   logic reset;
   always #5 core_clk = ~core_clk;

   lrn_window_buffer_if #(.DATA_WIDTH(DW), .M_WIDTH(MW)) bus ();

   lrn_window_buffer #(
      .DATA_WIDTH(DW), .M_WIDTH(MW), .DEPTH(DEPTH), .RD_LATENCY(L)
   ) dut (
      .core_clk(core_clk),
      .reset   (reset),
      .bus     (bus.slave)
   );

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;
   bit exp_ovf  = 1'b0;
   bit exp_cfg  = 1'b0;

   logic          pend_v [L];
   logic [DW-1:0] pend_d [L];

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Memory model: data for a read issued in cycle c is driven in cycle c+L.
   task automatic tick(input logic en, input logic [DW-1:0] d);
      bus.r_enable = en;
      bus.r_data   = pend_v[L-1] ? pend_d[L-1] : DW'($urandom);
      for (int i = L - 1; i > 0; i--) begin
         pend_v[i] = pend_v[i-1];
         pend_d[i] = pend_d[i-1];
      end
      pend_v[0] = en;
      pend_d[0] = d;
      @(posedge core_clk);
      #1;
      cyc++;
   endtask

   task automatic check_errs(input string tag);
      check_val({tag, "_ovf"}, 32'(bus.overflow_err), 32'(exp_ovf));
      check_val({tag, "_cfg"}, 32'(bus.config_err), 32'(exp_cfg));
   endtask

   // wb_mode 0: random write-backs from DRAIN entry; 1: one per handshake; 2: after the stream.
   task automatic run_window(input int dim, input int ready_pct, input int wb_mode,
                             input bit inject_ovf, input int abort_at);
      logic [DW-1:0] exp_q[$];
      logic [DW-1:0] got_q[$];
      int first_en, last_en, full_c, norm_low_c, norm_c, last_hs, first_hs, last_we;
      int n_we, stall_bad, issued, t0, exp_norm;
      bit was_norm, prev_stall, drop_checked, en, rdy, hs, we;
      logic [DW-1:0] prev_data, d;

      first_en = -1; last_en = -1; full_c = -1; norm_low_c = -1; norm_c = -1;
      last_hs = -1; first_hs = -1; last_we = -1; n_we = 0; stall_bad = 0; issued = 0;
      prev_stall = 1'b0; drop_checked = 1'b0; prev_data = '0;
      bus.dim3 = MW'(dim);
      bus.s_ready = 1'b0;
      bus.w_enable = 1'b0;
      was_norm = bus.normalized_window;

      t0 = cyc;
      while (cyc - t0 < 8 * dim + 20) begin
         if (was_norm && norm_low_c < 0 && !bus.normalized_window) norm_low_c = cyc;
         if (bus.full_flag) begin
            full_c = cyc;
            break;
         end
         en = (issued < dim) && ($urandom_range(0, 2) != 0);
         d  = DW'($urandom);
         if (en) begin
            if (first_en < 0) first_en = cyc;
            last_en = cyc;
            issued++;
            exp_q.push_back(d);
         end
         tick(en, d);
      end
      check_val("full_rise", 32'(full_c), 32'(last_en + L + 1));
      if (was_norm) check_val("norm_fall", 32'(norm_low_c), 32'(first_en + L + 1));

      t0 = cyc;
      while (cyc - t0 < 20 * dim + 40) begin
         if (abort_at >= 0 && cyc == full_c + abort_at) begin
            reset = 1'b1;
            tick(1'b0, '0);
            reset = 1'b0;
            exp_ovf = 1'b0;
            exp_cfg = 1'b0;
            check_val("rst_mid_svalid", 32'(bus.s_valid), 32'd0);
            check_val("rst_mid_full", 32'(bus.full_flag), 32'd0);
            check_val("rst_mid_norm", 32'(bus.normalized_window), 32'd0);
            check_val("rst_mid_sdata", 32'(bus.s_data), 32'd0);
            check_errs("rst_mid");
            bus.s_ready = 1'b0;
            bus.w_enable = 1'b0;
            tick(1'b0, '0);
            return;
         end
         if (cyc == full_c) check_val("svalid_lag", 32'(bus.s_valid), 32'd0);
         if (cyc == full_c + 1) check_val("svalid_rise", 32'(bus.s_valid), 32'd1);
         if (!drop_checked && last_hs >= 0 && cyc == last_hs + 1 && got_q.size() == dim) begin
            check_val("svalid_drop", 32'(bus.s_valid), 32'd0);
            drop_checked = 1'b1;
         end
         if (prev_stall && (!bus.s_valid || bus.s_data !== prev_data)) stall_bad++;
         if (bus.normalized_window) begin
            norm_c = cyc;
            break;
         end
         rdy = ($urandom_range(1, 100) <= ready_pct);
         hs  = bus.s_valid && rdy;
         case (wb_mode)
            0:       we = (n_we < dim) && ($urandom_range(0, 1) == 1);
            1:       we = hs && (n_we < dim);
            default: we = (n_we < dim) && (got_q.size() == dim);
         endcase
         if (hs) begin
            got_q.push_back(bus.s_data);
            if (first_hs < 0) first_hs = cyc;
            last_hs = cyc;
         end
         if (we) begin
            n_we++;
            last_we = cyc;
         end
         prev_stall = bus.s_valid && !rdy;
         prev_data  = bus.s_data;
         bus.s_ready  = rdy;
         bus.w_enable = we;
         if (inject_ovf && cyc == full_c && ERR_EN) exp_ovf = 1'b1;
         tick(inject_ovf && cyc == full_c, DW'($urandom));
      end
      bus.s_ready = 1'b0;
      bus.w_enable = 1'b0;

      check_val("stream_len", 32'(got_q.size()), 32'(dim));
      for (int i = 0; i < dim && i < got_q.size(); i++)
         check_val($sformatf("sample%0d", i), 32'(got_q[i]), 32'(exp_q[i]));
      check_val("stall_hold", 32'(stall_bad), 32'd0);
      exp_norm = ((last_hs > last_we) ? last_hs : last_we) + 1;
      check_val("norm_rise", 32'(norm_c), 32'(exp_norm));
      check_val("full_at_done", 32'(bus.full_flag), 32'd0);
      if (ready_pct == 100) check_val("no_bubble", 32'(last_hs - first_hs), 32'(dim - 1));
      check_errs("win");
      $display("window dim=%0d ready=%0d%% wb_mode=%0d ovf_inj=%0d samples=%0d norm_cycle=%0d",
               dim, ready_pct, wb_mode, inject_ovf, got_q.size(), norm_c);
   endtask

   task automatic cfg_test();
      bit was_norm;
      was_norm = bus.normalized_window;
      bus.dim3 = '0;
      tick(1'b1, 16'hBEEF);
      for (int i = 0; i < L + 1; i++) tick(1'b0, '0);
      if (ERR_EN) exp_cfg = 1'b1;
      check_errs("cfg");
      check_val("cfg_full", 32'(bus.full_flag), 32'd0);
      check_val("cfg_svalid", 32'(bus.s_valid), 32'd0);
      check_val("cfg_norm_hold", 32'(bus.normalized_window), 32'(was_norm));
      $display("config dim3=0 read: config_err=%0d normalized=%0d", bus.config_err,
               bus.normalized_window);
   endtask

   initial begin
      int dim;
      for (int i = 0; i < L; i++) begin
         pend_v[i] = 1'b0;
         pend_d[i] = '0;
      end
      reset = 1'b1;
      bus.dim3 = MW'(4);
      bus.r_enable = 1'b0;
      bus.r_data = '0;
      bus.s_ready = 1'b0;
      bus.w_enable = 1'b0;
      repeat (3) tick(1'b0, '0);
      check_val("rst_full", 32'(bus.full_flag), 32'd0);
      check_val("rst_svalid", 32'(bus.s_valid), 32'd0);
      check_val("rst_norm", 32'(bus.normalized_window), 32'd0);
      check_val("rst_sdata", 32'(bus.s_data), 32'd0);
      check_errs("rst");
      reset = 1'b0;
      tick(1'b0, '0);

      run_window(4, 100, 2, 1'b0, -1);
      run_window(4, 50, 1, 1'b0, -1);
      run_window(1, 100, 0, 1'b0, -1);
      run_window(6, 40, 0, 1'b1, -1);
      cfg_test();
      run_window(3, 100, 1, 1'b0, -1);
      for (int k = 0; k < 6; k++) begin
         dim = $urandom_range(1, 24);
         run_window(dim, $urandom_range(30, 100), $urandom_range(0, 2),
                    (dim >= 4) && ($urandom_range(0, 1) == 1), -1);
      end
      run_window(8, 30, 0, 1'b0, 3);
      run_window(5, 100, 1, 1'b0, -1);
      run_window(64, 100, 0, 1'b0, -1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
